cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Synthesizable run controller for the pipelined CPU. It replaces hand-toggled reset/clock sequencing.
//  Sequences the CPU's active-high reset, gates the CPU clock-enable for run/step/stop, and counts retired cycles.
//  Captures every cycle where out_flag is high into a small FIFO that the host drains through a valid/ready port.
//  Sits between the board/bench top and the CPU instance.
// PARAMETERS
//  WIDTH        16  CPU data-out width
//  CNTW         16  cycle counter / run-length width
//  HOLD_CYCLES  2   clocks cpu_reset is held high after a start (>=1)
//  DEPTH        8   capture FIFO entries (power of 2, >=2)
// PORTS
//  clock      in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-low
//  start      in   1        pulse: begin a reset + run sequence
//  step       in   1        pulse: advance exactly one CPU cycle; accepted only in PAUSE
//  stop       in   1        pulse: pause at the next clock
//  run_len    in   CNTW     cycles to run after reset; 0 = unbounded
//  cpu_reset  out  1        drives CPU reset, active-high
//  cpu_en     out  1        CPU clock enable
//  out_flag   in   1        CPU output strobe
//  out        in   WIDTH    CPU output data
//  cap_valid  out  1        capture FIFO not empty
//  cap_ready  in   1        host pops on cap_valid & cap_ready
//  cap_data   out  WIDTH    head entry data
//  cap_cycle  out  CNTW     head entry cycle stamp (optional, see CONFIGURATION)
//  cycle_cnt  out  CNTW     enabled CPU cycles since last start
//  busy       out  1        state is not IDLE or DONE
//  done       out  1        run_len reached; held until the next start
//  overflow   out  1        sticky: capture was dropped because the FIFO was full; cleared by start
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, cpu_reset=1, cpu_en=0, cycle_cnt=0, FIFO empty, cap_valid=0, done=0, overflow=0, busy=0.
//  States: IDLE, HOLD, RUN, PAUSE, DONE.
//  IDLE/DONE/PAUSE --start--> HOLD. On entry: cycle_cnt=0, done=0, overflow=0, FIFO flushed, run_len latched.
//  HOLD: cpu_reset=1, cpu_en=0 for exactly HOLD_CYCLES clocks, then RUN. cpu_reset falls on the same edge.
//  RUN: cpu_en=1 and cycle_cnt++ every clock. stop -> PAUSE. If latched len!=0 and cycle_cnt+1==len, go to DONE.
//   On the edge entering DONE the counter shows len and cpu_en drops to 0.
//  PAUSE: cpu_en=0. step -> cpu_en=1 for exactly one clock and cycle_cnt++, then back to PAUSE (or DONE if len is reached).
//   start -> HOLD. A second start while in RUN restarts the sequence (HOLD).
//  Priority on simultaneous pulses: start > stop > step. step outside PAUSE is ignored.
//  Capture: out_flag is sampled only on cycles with cpu_en=1, using the registered cpu_en.
//   Push {out, cycle_cnt} on that cycle. Push while full: the entry is dropped and overflow=1.
//   Push and pop in the same cycle when full: both occur, no drop.
//  Pop: on cap_valid & cap_ready. cap_data/cap_cycle are the registered head. Empty -> cap_valid=0 and data is don't-care.
//  cycle_cnt saturates at all-ones and does not wrap. FIFO pointers wrap modulo DEPTH using one extra bit for full/empty.
//  Asynchronous reset mid-run returns every output to its reset value immediately. The CPU is held in reset.
// CONFIGURATION
//  CPU_RUN_TIMESTAMP_EN defined: FIFO entries are WIDTH+CNTW wide and cap_cycle carries the stamp.
//  CPU_RUN_TIMESTAMP_EN undefined: entries are WIDTH wide and cap_cycle is tied to 0. The port list is unchanged.
// STRUCTURE
//  Package cpu_run_pkg holds:
//   - run_state_t enum (IDLE, HOLD, RUN, PAUSE, DONE)
//   - default localparams
//   - cap_entry_t struct
//  Sub-module capture_fifo #(DW, DEPTH) is a sync FIFO (push/full/pop/empty/dout) with async active-low reset.
//  The FSM, counter and enable logic stay in cpu_run_ctrl.
// TESTING
//  1 start, run_len=5, HOLD_CYCLES=2 -> cpu_reset high 2 clocks, cpu_en high 5 clocks, done=1, cycle_cnt=5, busy=0.
//  2 run_len=0, stop after 3 RUN clocks, then 2 step pulses -> cycle_cnt=5, cpu_en high exactly 1 clock per step.
//  3 out_flag high every enabled cycle, cap_ready=0, DEPTH=8, 10 cycles -> 8 entries, overflow=1, first cap_data = first out.
//  4 FIFO full with push+pop in the same cycle -> no drop, overflow stays 0, count stays 8.
//  5 start and stop in the same clock during RUN -> HOLD entered, cycle_cnt=0, FIFO empty, overflow=0.
//  6 reset low mid-RUN -> cpu_reset=1, cpu_en=0, cap_valid=0 without waiting for a clock edge.
//    With the timestamp macro defined, cap_cycle of the first entry equals the cycle number of its capture.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared types and default parameters for the CPU run controller.
package cpu_run_pkg;

  localparam int unsigned DefWidth      = 16;
  localparam int unsigned DefCntw       = 16;
  localparam int unsigned DefHoldCycles = 2;
  localparam int unsigned DefDepth      = 8;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StRun,
    StPause,
    StDone
  } run_state_t;

  // Capture entry layout at the default widths (data in the upper field, stamp below).
  typedef struct packed {
    logic [DefWidth-1:0] data;
    logic [DefCntw-1:0]  cycle;
  } cap_entry_t;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra bit to tell full from empty.
module capture_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign dout = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + (AW+1)'(push_ok);
    rd_d = rd_q + (AW+1)'(pop_ok);
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !flush) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: CPU reset sequencing, run/step/stop clock-enable, cycle count, output capture.
// Define CPU_RUN_TIMESTAMP_EN to store the cycle stamp alongside each captured output.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned CNTW        = DefCntw,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles,
  parameter int unsigned DEPTH       = DefDepth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic [CNTW-1:0]  run_len,
  output logic             cpu_reset,
  output logic             cpu_en,
  input  logic             out_flag,
  input  logic [WIDTH-1:0] out,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic [WIDTH-1:0] cap_data,
  output logic [CNTW-1:0]  cap_cycle,
  output logic [CNTW-1:0]  cycle_cnt,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef CPU_RUN_TIMESTAMP_EN
  localparam int unsigned DW = WIDTH + CNTW;
`else
  localparam int unsigned DW = WIDTH;
`endif

  run_state_t       state_q, state_d;
  logic             en_q, en_d;
  logic [CNTW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNTW-1:0]  len_q, len_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             ovf_q, ovf_d;
  logic             len_hit;

  logic             fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]    fifo_din, fifo_dout;

  assign cnt_inc    = cnt_q + CNTW'(1);
  // The enabled cycle in flight is the last one of the run.
  assign len_hit    = en_q && (len_q != '0) && (cnt_inc == len_q);
  assign fifo_push  = en_q && out_flag;
  assign fifo_pop   = cap_valid && cap_ready;

  always_comb begin
    state_d    = state_q;
    en_d       = 1'b0;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hold_d     = hold_q;
    ovf_d      = ovf_q;
    fifo_flush = 1'b0;

    if (en_q && (cnt_q != '1)) begin
      cnt_d = cnt_inc;
    end

    if (start) begin
      state_d    = StHold;
      hold_d     = '0;
      cnt_d      = '0;
      len_d      = run_len;
      ovf_d      = 1'b0;
      fifo_flush = 1'b1;
    end else begin
      unique case (state_q)
        StHold: begin
          if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
            state_d = StRun;
            en_d    = 1'b1;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
        StRun: begin
          if (len_hit) begin
            state_d = StDone;
          end else if (stop) begin
            state_d = StPause;
          end else begin
            en_d = 1'b1;
          end
        end
        StPause: begin
          // en_q high here means a single step is in flight; it always ends after one clock.
          if (len_hit) begin
            state_d = StDone;
          end else if (!en_q && !stop && step) begin
            en_d = 1'b1;
          end
        end
        default: ;
      endcase

      if (fifo_push && fifo_full && !fifo_pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef CPU_RUN_TIMESTAMP_EN
  assign fifo_din  = {out, cnt_q};
  assign cap_data  = fifo_dout[DW-1 -: WIDTH];
  assign cap_cycle = fifo_dout[CNTW-1:0];
`else
  assign fifo_din  = out;
  assign cap_data  = fifo_dout;
  assign cap_cycle = '0;
`endif

  capture_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_capture_fifo (
    .clock (clock),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign cpu_reset = (state_q == StIdle) || (state_q == StHold);
  assign cpu_en    = en_q;
  assign cap_valid = !fifo_empty;
  assign cycle_cnt = cnt_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign overflow  = ovf_q;

endmodule
